// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } kp_state_e;

  // Matrix position to key code: row-major, so row r starts at r*cols.
  function automatic int code_of(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - valid/ready key-code handshake bundle
interface keypad_scanner_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;

  modport master (
    output key_code,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    output key_ready
  );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser, resets to all ones (idle pull-up level)
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column-scanning, debouncing keypad encoder with valid/ready output
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   rows_n,
  output logic [COLS-1:0]   cols_n,
  keypad_scanner_if.master  key_if,
  output logic              key_pressed,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int CODE_W = $clog2(ROWS * COLS);
  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);
  localparam int DW     = $clog2(SCAN_DIV);
  localparam int NW     = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [NW-1:0] DEB_LAST   = NW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

  logic [ROWS-1:0]   rows_sync;
  logic [ROWS-1:0]   rs;
  logic [RW-1:0]     row_sel;
  logic              rs_hit;
  logic [CW-1:0]     col_next;
  logic [CODE_W-1:0] code_new;

  kp_state_e         state_q, state_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              pressed_q, pressed_d;
  logic              push;

  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              pop;

  sync_2ff #(.W(ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rows_n),
    .q_o   (rows_sync)
  );

  assign rs       = ~rows_sync;
  assign rs_hit   = rs[row_q];
  assign col_next = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
  assign code_new = CODE_W'(code_of(int'(row_q), int'(col_q), COLS));

  // Lowest active row wins when several rows answer on one column.
  always_comb begin
    row_sel = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (rs[i]) row_sel = RW'(i);
    end
  end

  // Scan/debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      dwell_q   <= '0;
      cnt_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pressed_q <= pressed_d;
    end
  end

  // Next-state logic: scan columns, qualify a press, then wait for a clean release.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    pressed_d = pressed_q;
    push      = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (|rs) begin
            row_d   = row_sel;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (rs_hit) begin
          if (cnt_q == DEB_LAST) begin
            push      = 1'b1;
            pressed_d = 1'b1;
            cnt_d     = '0;
            state_d   = RELEASE;
          end else begin
            cnt_d = cnt_q + NW'(1);
          end
        end else begin
          // Row dropped before qualifying: treat as bounce/noise and move on.
          col_d   = col_next;
          dwell_d = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      RELEASE: begin
        if (!rs_hit) begin
          if (cnt_q == DEB_LAST) begin
            pressed_d = 1'b0;
            col_d     = col_next;
            dwell_d   = '0;
            cnt_d     = '0;
            state_d   = SCAN;
          end else begin
            cnt_d = cnt_q + NW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = SCAN;
        dwell_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output holding register and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // A push may reuse the slot freed by a same-cycle pop; an overflow set beats a clear.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    pop     = valid_q & key_if.key_ready;
    if (pop) valid_d = 1'b0;
    if (ovf_clr) ovf_d = 1'b0;
    if (push) begin
      if (!valid_q || pop) begin
        code_d  = code_new;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign cols_n           = ~(COLS'(1) << col_q);
  assign key_if.key_code  = code_q;
  assign key_if.key_valid = valid_q;
  assign key_pressed      = pressed_q;
  assign overflow         = ovf_q;

endmodule
